// File: rtl/fnd_capture.sv
// fnd_capture: receive side of the FND segment encoder.
// Samples a multiplexed active-low 7-segment bus with a one-hot digit select.
// Each pattern that stays stable for STABLE_CYC synchronized cycles is decoded
// back to hex and stored per digit.
// Optional feature: define FND_CAPTURE_FRAME_EN to add o_frame. o_frame pulses
// once every digit has been captured at least once since the last pulse.
module fnd_capture #(
  parameter int unsigned N_DIG      = 4,
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [6:0]         i_seg,
  input  logic [N_DIG-1:0]   i_dig,
  input  logic               i_clr,
  output logic [4*N_DIG-1:0] o_hex,
  output logic [N_DIG-1:0]   o_blank,
  output logic [N_DIG-1:0]   o_err,
  output logic [N_DIG-1:0]   o_upd_dig
`ifdef FND_CAPTURE_FRAME_EN
  ,
  output logic               o_frame
`endif
);

  localparam logic [1:0] StWait   = 2'd0;
  localparam logic [1:0] StSettle = 2'd1;
  localparam logic [1:0] StHold   = 2'd2;

  localparam logic [7:0]       StableCyc = 8'(STABLE_CYC);
  localparam logic [N_DIG-1:0] DigOne    = N_DIG'(1);
  localparam logic [6:0]       SegBlank  = 7'b1111111;

  // Segment pattern to {valid, hex}. Bit order is g..a, active-low.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b1000000: r = 5'h10;
      7'b1111001: r = 5'h11;
      7'b0100100: r = 5'h12;
      7'b0110000: r = 5'h13;
      7'b0011001: r = 5'h14;
      7'b0010010: r = 5'h15;
      7'b0000010: r = 5'h16;
      7'b1011000: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0011000: r = 5'h19;
      7'b0001000: r = 5'h1a;
      7'b0000011: r = 5'h1b;
      7'b0100111: r = 5'h1c;
      7'b0100001: r = 5'h1d;
      7'b0000110: r = 5'h1e;
      7'b0001110: r = 5'h1f;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  logic [6:0]         seg_m, seg_s, seg_p;
  logic [N_DIG-1:0]   dig_m, dig_s, dig_p;
  logic [1:0]         state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               cap;
  logic               dig_onehot;
  logic               changed;
  logic [4:0]         dec;
  logic [4*N_DIG-1:0] hex_q, hex_d;
  logic [N_DIG-1:0]   blank_q, blank_d;
  logic [N_DIG-1:0]   err_q, err_d;
  logic [N_DIG-1:0]   upd_q, upd_d;

  // Two-flop synchronizers, plus a copy of the previous synchronized pair
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      seg_m <= '0;
      seg_s <= '0;
      seg_p <= '0;
      dig_m <= '0;
      dig_s <= '0;
      dig_p <= '0;
    end else begin
      seg_m <= i_seg;
      seg_s <= seg_m;
      seg_p <= seg_s;
      dig_m <= i_dig;
      dig_s <= dig_m;
      dig_p <= dig_s;
    end
  end

  assign dig_onehot = (dig_s != '0) && ((dig_s & (dig_s - DigOne)) == '0);
  assign changed    = {dig_s, seg_s} != {dig_p, seg_p};
  assign dec        = decode(seg_s);

  // Settle FSM: capture once per stable period of the synchronized pair
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    case (state_q)
      StWait: begin
        if (dig_onehot) begin
          state_d = StSettle;
          cnt_d   = 8'd1;
        end else begin
          cnt_d = 8'd0;
        end
      end
      StSettle: begin
        if (!dig_onehot) begin
          state_d = StWait;
          cnt_d   = 8'd0;
        end else if (changed) begin
          cnt_d = 8'd1;
        end else if (cnt_q >= StableCyc) begin
          cap     = 1'b1;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHold: begin
        if (!dig_onehot) begin
          state_d = StWait;
          cnt_d   = 8'd0;
        end else if (changed) begin
          state_d = StSettle;
          cnt_d   = 8'd1;
        end
      end
      default: begin
        state_d = StWait;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Register-file update for the selected digit
  always_comb begin
    hex_d   = hex_q;
    blank_d = blank_q;
    // A capture error on the same cycle as i_clr overrides the clear
    err_d   = i_clr ? '0 : err_q;
    upd_d   = cap ? dig_s : '0;
    for (int k = 0; k < N_DIG; k++) begin
      if (cap && dig_s[k]) begin
        if (dec[4]) begin
          hex_d[4*k +: 4] = dec[3:0];
          blank_d[k]      = 1'b0;
        end else if (seg_s == SegBlank) begin
          blank_d[k] = 1'b1;
        end else begin
          err_d[k] = 1'b1;
        end
      end
    end
  end

  // FSM and register-file state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StWait;
      cnt_q   <= '0;
      hex_q   <= '0;
      blank_q <= '1;
      err_q   <= '0;
      upd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      blank_q <= blank_d;
      err_q   <= err_d;
      upd_q   <= upd_d;
    end
  end

  assign o_hex     = hex_q;
  assign o_blank   = blank_q;
  assign o_err     = err_q;
  assign o_upd_dig = upd_q;

`ifdef FND_CAPTURE_FRAME_EN
  logic [N_DIG-1:0] seen_q, seen_d, seen_or;
  logic             frame_q, frame_d;

  // Seen mask: the capture that completes it fires o_frame and clears it
  always_comb begin
    seen_or = seen_q | upd_d;
    seen_d  = seen_q;
    frame_d = 1'b0;
    if (cap) begin
      if (seen_or == '1) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end else begin
        seen_d = seen_or;
      end
    end
  end

  // Frame state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      seen_q  <= '0;
      frame_q <= 1'b0;
    end else begin
      seen_q  <= seen_d;
      frame_q <= frame_d;
    end
  end

  assign o_frame = frame_q;
`endif

endmodule

// File: tb/tb_fnd_capture.sv
// Directed bench for fnd_capture (N_DIG=4, STABLE_CYC=4).
module tb_fnd_capture;

  localparam int unsigned N_DIG      = 4;
  localparam int unsigned STABLE_CYC = 4;

  logic               i_clk;
  logic               i_rst;
  logic [6:0]         i_seg;
  logic [N_DIG-1:0]   i_dig;
  logic               i_clr;
  logic [4*N_DIG-1:0] o_hex;
  logic [N_DIG-1:0]   o_blank;
  logic [N_DIG-1:0]   o_err;
  logic [N_DIG-1:0]   o_upd_dig;
`ifdef FND_CAPTURE_FRAME_EN
  logic               o_frame;
`endif

  fnd_capture #(
    .N_DIG      (N_DIG),
    .STABLE_CYC (STABLE_CYC)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_seg     (i_seg),
    .i_dig     (i_dig),
    .i_clr     (i_clr),
    .o_hex     (o_hex),
    .o_blank   (o_blank),
    .o_err     (o_err),
    .o_upd_dig (o_upd_dig)
`ifdef FND_CAPTURE_FRAME_EN
    ,
    .o_frame   (o_frame)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // n = edges after the first edge that sees the new input, until o_upd_dig rises
  task automatic wait_upd(output int n, output logic [N_DIG-1:0] upd);
    n = 0;
    tick();
    while (o_upd_dig == '0 && n < 40) begin
      tick();
      n++;
    end
    upd = o_upd_dig;
  endtask

  logic [6:0]       pats [4] = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
  int               n;
  int               pulses;
  logic [N_DIG-1:0] upd;
  int               upd_cnt  [4];
  logic [N_DIG-1:0] upd_seen [4];
  int               fcnt;
  logic [N_DIG-1:0] fupd;

  initial begin
    i_rst = 1'b1;
    i_seg = 7'b1111111;
    i_dig = '0;
    i_clr = 1'b0;
    #12;
    chk("rst_hex", 32'(o_hex), 32'h0000);
    chk("rst_blank", 32'(o_blank), 32'hf);
    chk("rst_err", 32'(o_err), 32'h0);
    chk("rst_upd", 32'(o_upd_dig), 32'h0);
    @(negedge i_clk);
    i_rst = 1'b0;
    tick();

    // Single capture of '2' on digit 1
    i_dig = 4'b0010;
    i_seg = 7'b0100100;
    wait_upd(n, upd);
    chk("lat1", 32'(n), 32'(STABLE_CYC + 2));
    chk("upd1", 32'(upd), 32'b0010);
    chk("hex1", 32'(o_hex[7:4]), 32'h2);
    chk("blank1", 32'(o_blank), 32'b1101);
    pulses = 0;
    repeat (10) begin
      tick();
      if (o_upd_dig != '0) pulses++;
    end
    chk("nodup1", 32'(pulses), 32'd0);

    // Glitch: '2' for two cycles then '3' on digit 2
    i_dig = 4'b0100;
    i_seg = 7'b0100100;
    tick();
    tick();
    i_seg = 7'b0110000;
    wait_upd(n, upd);
    chk("lat2", 32'(n), 32'(STABLE_CYC + 2));
    chk("upd2", 32'(upd), 32'b0100);
    chk("hex2", 32'(o_hex[11:8]), 32'h3);

    // Digit 0: '8', then blank, then illegal, then clear
    i_dig = 4'b0001;
    i_seg = 7'b0000000;
    wait_upd(n, upd);
    chk("upd3", 32'(upd), 32'b0001);
    chk("hex3", 32'(o_hex[3:0]), 32'h8);
    chk("blank3", 32'(o_blank[0]), 32'd0);
    i_seg = 7'b1111111;
    wait_upd(n, upd);
    chk("upd4", 32'(upd), 32'b0001);
    chk("blank4", 32'(o_blank[0]), 32'd1);
    chk("hex4", 32'(o_hex[3:0]), 32'h8);
    i_seg = 7'b0101010;
    wait_upd(n, upd);
    chk("upd5", 32'(upd), 32'b0001);
    chk("err5", 32'(o_err), 32'b0001);
    chk("hex5", 32'(o_hex[3:0]), 32'h8);
    chk("blank5", 32'(o_blank[0]), 32'd1);
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    chk("clr", 32'(o_err), 32'h0);

    // Non-one-hot select never captures
    i_dig = 4'b0011;
    i_seg = 7'b0110000;
    pulses = 0;
    repeat (20) begin
      tick();
      if (o_upd_dig != '0) pulses++;
    end
    chk("nonhot", 32'(pulses), 32'd0);
    chk("nonhot_hex", 32'(o_hex), 32'h0328);

    // Asynchronous reset between edges
    #2;
    i_rst = 1'b1;
    #1;
    chk("arst_hex", 32'(o_hex), 32'h0000);
    chk("arst_blank", 32'(o_blank), 32'hf);
    i_dig = '0;
    @(negedge i_clk);
    i_rst = 1'b0;
    tick();

    // Full scan 1,2,3,4 over digits 0..3
    fcnt = 0;
    fupd = '0;
    for (int d = 0; d < 4; d++) begin
      upd_cnt[d]  = 0;
      upd_seen[d] = '0;
      i_dig = N_DIG'(1) << d;
      i_seg = pats[d];
      repeat (8) begin
        tick();
        if (o_upd_dig != '0) begin
          upd_cnt[d]++;
          upd_seen[d] = upd_seen[d] | o_upd_dig;
        end
`ifdef FND_CAPTURE_FRAME_EN
        if (o_frame) begin
          fcnt++;
          fupd = o_upd_dig;
        end
`endif
      end
    end
    i_dig = '0;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("scan_cnt%0d", d), 32'(upd_cnt[d]), 32'd1);
      chk($sformatf("scan_dig%0d", d), 32'(upd_seen[d]), 32'(N_DIG'(1) << d));
    end
    chk("scan_hex", 32'(o_hex), 32'h4321);
    chk("scan_blank", 32'(o_blank), 32'h0);
`ifdef FND_CAPTURE_FRAME_EN
    chk("frame_cnt", 32'(fcnt), 32'd1);
    chk("frame_dig", 32'(fupd), 32'b1000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fnd_capture.md
Name: fnd_capture

Overview:
- Receive-side counterpart of the FND segment encoder.
- Samples a multiplexed 7-segment bus: active-low segment lines plus a one-hot digit select.
- Decodes each stable segment pattern back to a 4-bit hex value and stores it in a per-digit register file.
- Used for display loopback self-test and for reading back the scanned score display.

Parameters:
N_DIG, 4, number of multiplexed digits (1..8)
STABLE_CYC, 4, consecutive identical synchronized samples required before capture (2..255)

Ports:
i_clk  input  1  system clock
i_rst  input  1  asynchronous active-high reset
i_seg  input  7  segment lines, active-low, bit0=a .. bit6=g
i_dig  input  N_DIG  digit select, active-high, one-hot when valid
i_clr  input  1  synchronous clear of o_err
o_hex  output  4*N_DIG  decoded value per digit; digit k occupies bits [4k+3:4k]
o_blank  output  N_DIG  digit k last captured as blank (7'b1111111)
o_err  output  N_DIG  sticky: digit k captured an undecodable pattern
o_upd_dig  output  N_DIG  one-cycle one-hot pulse marking the digit just captured

Behaviour:
- Reset: one clock; i_rst is asynchronous and active-high. While i_rst is high all flops clear: o_hex=0, o_blank=all 1s, o_err=0, o_upd_dig=0, synchronizers=0, stability counter=0, FSM=WAIT. Reset mid-settle discards the pending capture.
- Input synchronization: i_seg and i_dig each pass through a 2-flop synchronizer. The synchronized pair is P = {dig_s, seg_s}.
- Stability counter cnt:
  - cnt=1 on the first cycle P is a valid one-hot pair after a change.
  - cnt increments each cycle P equals its previous-cycle value.
  - cnt saturates at STABLE_CYC.
- FSM:
  - WAIT: dig_s is zero or not one-hot. No capture. Go to SETTLE when dig_s becomes one-hot.
  - SETTLE: counting. Any change in P restarts cnt at 1, or returns to WAIT if dig_s is no longer one-hot. When cnt reaches STABLE_CYC: capture, go to HOLD.
  - HOLD: exactly one capture per stable period. Any change in P goes to SETTLE (cnt=1) or WAIT.
- Capture, registered, visible in the cycle after cnt reaches STABLE_CYC:
  - Update digit k = index of the set bit in dig_s.
  - o_upd_dig[k]=1 for exactly one cycle.
  - Latency: an input held constant from clock edge t produces o_upd_dig at edge t+STABLE_CYC+2.
- Decode table, seg -> hex:
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3
  - 0011001->4, 0010010->5, 0000010->6, 1011000->7
  - 0000000->8, 0011000->9, 0001000->A, 0000011->B
  - 0100111->C, 0100001->D, 0000110->E, 0001110->F
- Capture outcome by pattern:
  - Pattern in table: o_hex[k] = value, o_blank[k]=0.
  - 1111111: o_blank[k]=1, o_hex[k] unchanged.
  - Any other pattern: o_err[k] set, o_hex[k] and o_blank[k] unchanged.
- i_clr: clears all o_err bits next cycle. If a capture sets o_err[k] in the same cycle as i_clr, the set wins for bit k.
- Unaddressed digits hold their values indefinitely; there is no timeout.

Optional Feature:
- Macro: FND_CAPTURE_FRAME_EN.
- Defined: adds output o_frame (1 bit) and an internal N_DIG-bit seen mask.
  - Each capture ORs in its digit bit.
  - When the mask becomes all ones, o_frame pulses for one cycle, coincident with that o_upd_dig, and the mask clears in the same cycle.
  - Reset clears the mask.
- Undefined: no o_frame port, no mask logic. All other behaviour identical.

Test Plan:
- Reset: assert i_rst asynchronously between clock edges -> outputs take reset values immediately; o_blank=4'b1111, o_hex=16'h0000.
- Single capture, STABLE_CYC=4: hold i_dig=4'b0010, i_seg=7'b0100100 -> o_upd_dig=4'b0010 exactly 6 cycles later, for one cycle; o_hex[7:4]=4'h2; no second pulse while held.
- Glitch rejection: i_seg toggles 0100100 -> 0110000 after 2 stable cycles, then holds -> single capture of 4'h3 only, 6 cycles after the change.
- Illegal and blank patterns: digit 0 gets 7'b1111111 -> o_blank[0]=1, o_hex[3:0] unchanged; then 7'b0101010 -> o_err[0]=1; i_clr pulse -> o_err=0.
- Non-one-hot select: i_dig=4'b0011 held 20 cycles -> no o_upd_dig, FSM stays in WAIT.
- Full scan, FND_CAPTURE_FRAME_EN defined: scan digits 0..3 with patterns for 1,2,3,4, each held 8 cycles -> o_hex=16'h4321; o_frame pulses with the digit-3 capture only.
